// File: rtl/rvm_mul_seq_pkg.sv
// Shared constants for the sequential multiplier: adder op codes,
// multiply op codes and FSM state encodings.
package rvm_mul_seq_pkg;

    localparam logic [2:0] RVM_ARITH_NOP = 3'd0;
    localparam logic [2:0] RVM_ARITH_ADD = 3'd1;
    localparam logic [2:0] RVM_ARITH_SUB = 3'd2;

    localparam logic [1:0] RVM_MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] RVM_MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] RVM_MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] RVM_MUL_OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mul_state_t;

    // Only MUL returns the low product word; every other op returns the high word.
    function automatic logic mul_sel_hi(input logic [1:0] op);
        return op != RVM_MUL_OP_MUL;
    endfunction

endpackage

// File: rtl/rvm_mul_seq_if.sv
// Request/response handshake plus the borrowed shared-adder port.
// slave: the multiplier. master: the core side that also owns the adder.
interface rvm_mul_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_lhs;
    logic [31:0] req_rhs;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [31:0] add_lhs;
    logic [31:0] add_rhs;
    logic [2:0]  add_op;
    logic        add_valid;
    logic [32:0] add_result;

    modport slave (
        input  req_valid, req_op, req_lhs, req_rhs, rsp_ready, add_valid, add_result,
        output req_ready, rsp_valid, rsp_result, add_lhs, add_rhs, add_op
    );

    modport master (
        output req_valid, req_op, req_lhs, req_rhs, rsp_ready, add_valid, add_result,
        input  req_ready, rsp_valid, rsp_result, add_lhs, add_rhs, add_op
    );
endinterface

// File: rtl/rvm_mul_seq_sign.sv
// Combinational sign helpers for the multiplier: operand magnitudes,
// result sign and 64-bit negate. Real logic only when RVM_MUL_SIGNED_EN
// is defined; otherwise plain pass-through wiring.
module rvm_mul_sign
    import rvm_mul_seq_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    input  logic [63:0] prod,
    output logic [31:0] lhs_abs,
    output logic [31:0] rhs_abs,
    output logic        neg,
    output logic [63:0] prod_neg
);
`ifdef RVM_MUL_SIGNED_EN
    logic lhs_signed;
    logic rhs_signed;

    // |0x80000000| wraps to 0x80000000, which is the right magnitude unsigned.
    assign lhs_signed = (op == RVM_MUL_OP_MULH) || (op == RVM_MUL_OP_MULHSU);
    assign rhs_signed = (op == RVM_MUL_OP_MULH);
    assign lhs_abs    = (lhs_signed && lhs[31]) ? (~lhs + 32'd1) : lhs;
    assign rhs_abs    = (rhs_signed && rhs[31]) ? (~rhs + 32'd1) : rhs;
    assign neg        = (lhs_signed & lhs[31]) ^ (rhs_signed & rhs[31]);
    assign prod_neg   = ~prod + 64'd1;
`else
    logic unused_op;

    assign unused_op = ^op;
    assign lhs_abs   = lhs;
    assign rhs_abs   = rhs;
    assign neg       = 1'b0;
    assign prod_neg  = prod;
`endif
endmodule

// File: rtl/rvm_mul_seq.sv
// Iterative 32x32 shift-add multiplier that borrows the shared adder for
// every partial-product add. Signed MULH/MULHSU need RVM_MUL_SIGNED_EN;
// without it they are computed as MULHU.
//
// state | meaning
// IDLE  | ready for a request
// ITER  | one multiplier bit per commit, 32 commits
// FIX   | negate the 64-bit product (signed ops, negative result)
// DONE  | result presented until rsp_ready
module rvm_mul_seq
    import rvm_mul_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          reset,
    rvm_mul_seq_if.slave bus
);
    mul_state_t      state_q, state_d;
    logic [XLEN-1:0] mcand, acc_hi, acc_lo;
    logic [5:0]      cnt;
    logic [1:0]      op_q;
    logic            accept, commit, fix;
    logic [XLEN:0]   sum;
    logic [31:0]     lhs_abs, rhs_abs;
    logic            sign_neg;
    logic [63:0]     prod_neg;

    rvm_mul_sign u_sign (
        .op      (bus.req_op),
        .lhs     (bus.req_lhs),
        .rhs     (bus.req_rhs),
        .prod    ({acc_hi, acc_lo}),
        .lhs_abs (lhs_abs),
        .rhs_abs (rhs_abs),
        .neg     (sign_neg),
        .prod_neg(prod_neg)
    );

`ifdef RVM_MUL_SIGNED_EN
    logic neg;

    // Result sign is captured with the operands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       neg <= 1'b0;
        else if (accept) neg <= sign_neg;
    end
`else
    logic unused_sign;
    assign unused_sign = ^{sign_neg, prod_neg};
`endif

    // Without an add this iteration, the carry-in row is just acc_hi.
    assign sum = acc_lo[0] ? bus.add_result : {1'b0, acc_hi};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state, handshake outputs and adder drive.
    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        commit         = 1'b0;
        fix            = 1'b0;
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_result = '0;
        bus.add_op     = RVM_ARITH_NOP;
        bus.add_lhs    = '0;
        bus.add_rhs    = '0;
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
                if (acc_lo[0]) begin
                    bus.add_op  = RVM_ARITH_ADD;
                    bus.add_lhs = acc_hi;
                    bus.add_rhs = mcand;
                end
                commit = !acc_lo[0] || bus.add_valid;
                if (commit && cnt == 6'(XLEN - 1)) begin
`ifdef RVM_MUL_SIGNED_EN
                    state_d = neg ? ST_FIX : ST_DONE;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef RVM_MUL_SIGNED_EN
            ST_FIX: begin
                fix     = 1'b1;
                state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                bus.rsp_valid  = 1'b1;
                bus.rsp_result = mul_sel_hi(op_q) ? acc_hi : acc_lo;
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, shift-add commit and final negate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            op_q   <= RVM_MUL_OP_MUL;
        end else if (accept) begin
            mcand  <= lhs_abs;
            acc_lo <= rhs_abs;
            acc_hi <= '0;
            cnt    <= '0;
            op_q   <= bus.req_op;
        end else if (commit) begin
            {acc_hi, acc_lo} <= {sum, acc_lo[XLEN-1:1]};
            cnt              <= cnt + 6'd1;
        end else if (fix) begin
            {acc_hi, acc_lo} <= prod_neg;
        end
    end
endmodule

// File: tb/tb_rvm_mul_seq.sv
// Directed bench for rvm_mul_seq with a behavioural shared adder that can
// hold add_valid low for a programmable number of cycles per ADD.
module tb_rvm_mul_seq;
    import rvm_mul_seq_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;
    int   stall_cycles = 0;
    int   wait_cnt = 0;

    rvm_mul_seq_if bus ();

    rvm_mul_seq dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Shared adder model: sum is always correct, valid after stall_cycles.
    assign bus.add_result = {1'b0, bus.add_lhs} + {1'b0, bus.add_rhs};
    assign bus.add_valid  = (bus.add_op == RVM_ARITH_ADD) && (wait_cnt == stall_cycles);

    always @(posedge clk) begin
        if (bus.add_op == RVM_ARITH_ADD && wait_cnt != stall_cycles) wait_cnt <= wait_cnt + 1;
        else                                                         wait_cnt <= 0;
    end

    // Issue one request, count edges from the accept edge until rsp_valid,
    // then complete the response handshake. cycles = -1 on timeout.
    task automatic do_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] result, output int cycles);
        int n;
        n = 0;
        cycles = -1;
        result = 32'h0;
        bus.req_op    = op;
        bus.req_lhs   = a;
        bus.req_rhs   = b;
        bus.req_valid = 1'b1;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            bus.req_valid = 1'b0;
            if (bus.rsp_valid) begin
                cycles = n;
                result = bus.rsp_result;
                break;
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_assert++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
        n_assert++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        n_assert++; if (bus.rsp_result !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_result got %h want 0", bus.rsp_result); end
        n_assert++; if (bus.add_op !== RVM_ARITH_NOP) begin n_fail++; $display("FAIL reset_add_op got %0d want 0", bus.add_op); end
        n_assert++; if (bus.add_lhs !== 32'h0) begin n_fail++; $display("FAIL reset_add_lhs got %h want 0", bus.add_lhs); end
        n_assert++; if (bus.add_rhs !== 32'h0) begin n_fail++; $display("FAIL reset_add_rhs got %h want 0", bus.add_rhs); end
    endtask

    task automatic test_max_operands();
        logic [31:0] r;
        int c;
        do_mul(RVM_MUL_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, c);
        n_assert++; if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu_max got %h want fffffffe", r); end
        n_assert++; if (c !== 33) begin n_fail++; $display("FAIL mulhu_max_latency got %0d want 33", c); end
        do_mul(RVM_MUL_OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, c);
        n_assert++; if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL mul_max got %h want 00000001", r); end
        n_assert++; if (c !== 33) begin n_fail++; $display("FAIL mul_max_latency got %0d want 33", c); end
    endtask

    task automatic test_zero();
        logic [31:0] r;
        int c;
        do_mul(RVM_MUL_OP_MUL, 32'h0000_0000, 32'h0000_1234, r, c);
        n_assert++; if (r !== 32'h0) begin n_fail++; $display("FAIL zero_lhs got %h want 0", r); end
        n_assert++; if (c !== 33) begin n_fail++; $display("FAIL zero_lhs_latency got %0d want 33", c); end
        do_mul(RVM_MUL_OP_MULHU, 32'hDEAD_BEEF, 32'h0000_0000, r, c);
        n_assert++; if (r !== 32'h0) begin n_fail++; $display("FAIL zero_rhs got %h want 0", r); end
        n_assert++; if (c !== 33) begin n_fail++; $display("FAIL zero_rhs_latency got %0d want 33", c); end
        do_mul(RVM_MUL_OP_MULHU, 32'h8000_0000, 32'h0000_0004, r, c);
        n_assert++; if (r !== 32'h0000_0002) begin n_fail++; $display("FAIL mulhu_shift got %h want 00000002", r); end
    endtask

    task automatic test_stall();
        int n, stalls;
        logic prev_stall;
        logic [31:0] prev_lhs, prev_rhs;
        n = 0;
        stalls = 0;
        prev_stall = 1'b0;
        prev_lhs = '0;
        prev_rhs = '0;
        stall_cycles = 2;
        bus.req_op    = RVM_MUL_OP_MUL;
        bus.req_lhs   = 32'h0000_0007;
        bus.req_rhs   = 32'h0000_0006;
        bus.req_valid = 1'b1;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            bus.req_valid = 1'b0;
            if (prev_stall) begin
                n_assert++;
                if (bus.add_op !== RVM_ARITH_ADD || bus.add_lhs !== prev_lhs || bus.add_rhs !== prev_rhs) begin
                    n_fail++;
                    $display("FAIL stall_inputs_stable got op=%0d lhs=%h rhs=%h want op=1 lhs=%h rhs=%h",
                             bus.add_op, bus.add_lhs, bus.add_rhs, prev_lhs, prev_rhs);
                end
            end
            prev_stall = (bus.add_op == RVM_ARITH_ADD) && !bus.add_valid;
            prev_lhs   = bus.add_lhs;
            prev_rhs   = bus.add_rhs;
            if (prev_stall) stalls++;
            if (bus.rsp_valid) break;
        end
        n_assert++; if (bus.rsp_result !== 32'h0000_002A) begin n_fail++; $display("FAIL stall_result got %h want 0000002a", bus.rsp_result); end
        n_assert++; if (n !== 37) begin n_fail++; $display("FAIL stall_latency got %0d want 37", n); end
        n_assert++; if (stalls !== 4) begin n_fail++; $display("FAIL stall_count got %0d want 4", stalls); end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        stall_cycles = 0;
    endtask

    task automatic test_rsp_hold();
        int n;
        n = 0;
        bus.req_op    = RVM_MUL_OP_MUL;
        bus.req_lhs   = 32'h1234_5678;
        bus.req_rhs   = 32'h0000_0010;
        bus.req_valid = 1'b1;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            bus.req_valid = 1'b0;
            if (bus.rsp_valid) break;
        end
        for (int i = 0; i < 5; i++) begin
            n_assert++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'h2345_6780 || bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d got valid=%b result=%h ready=%b want valid=1 result=23456780 ready=0",
                         i, bus.rsp_valid, bus.rsp_result, bus.req_ready);
            end
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        n_assert++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release got ready=%b valid=%b want ready=1 valid=0", bus.req_ready, bus.rsp_valid); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        int c, seen;
        seen = 0;
        bus.req_op    = RVM_MUL_OP_MUL;
        bus.req_lhs   = 32'hFFFF_FFFF;
        bus.req_rhs   = 32'hFFFF_FFFF;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_assert++;
        if (bus.req_ready !== 1'b1 || bus.add_op !== RVM_ARITH_NOP || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state got ready=%b op=%0d valid=%b want ready=1 op=0 valid=0",
                     bus.req_ready, bus.add_op, bus.rsp_valid);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) seen++;
        end
        n_assert++; if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_rsp got %0d valid cycles want 0", seen); end
        n_assert++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_idle got ready=%b want 1", bus.req_ready); end
        do_mul(RVM_MUL_OP_MUL, 32'd3, 32'd5, r, c);
        n_assert++; if (r !== 32'd15) begin n_fail++; $display("FAIL midreset_next got %h want 0000000f", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int c;
        n_assert++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", bus.req_ready); end
        do_mul(RVM_MUL_OP_MUL, 32'h0001_0001, 32'h0000_0003, r, c);
        n_assert++; if (r !== 32'h0003_0003) begin n_fail++; $display("FAIL b2b_first got %h want 00030003", r); end
        do_mul(RVM_MUL_OP_MULHU, 32'h0001_0000, 32'h0001_0000, r, c);
        n_assert++; if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL b2b_second got %h want 00000001", r); end
    endtask

    task automatic test_signed_ops();
        logic [31:0] r;
        int c;
`ifdef RVM_MUL_SIGNED_EN
        do_mul(RVM_MUL_OP_MULH, 32'hFFFF_FFFF, 32'h0000_0002, r, c);
        n_assert++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulh_neg got %h want ffffffff", r); end
        n_assert++; if (c !== 34) begin n_fail++; $display("FAIL mulh_neg_latency got %0d want 34", c); end
        do_mul(RVM_MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, c);
        n_assert++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulhsu_neg got %h want ffffffff", r); end
        do_mul(RVM_MUL_OP_MULH, 32'h8000_0000, 32'h8000_0000, r, c);
        n_assert++; if (r !== 32'h4000_0000) begin n_fail++; $display("FAIL mulh_minint got %h want 40000000", r); end
        n_assert++; if (c !== 33) begin n_fail++; $display("FAIL mulh_minint_latency got %0d want 33", c); end
`else
        do_mul(RVM_MUL_OP_MULH, 32'hFFFF_FFFF, 32'h0000_0002, r, c);
        n_assert++; if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL mulh_unsigned got %h want 00000001", r); end
        n_assert++; if (c !== 33) begin n_fail++; $display("FAIL mulh_unsigned_latency got %0d want 33", c); end
        do_mul(RVM_MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, c);
        n_assert++; if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhsu_unsigned got %h want fffffffe", r); end
`endif
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_lhs   = 32'h0;
        bus.req_rhs   = 32'h0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        test_max_operands();
        test_zero();
        test_stall();
        test_rsp_hold();
        test_reset_mid();
        test_back_to_back();
        test_signed_ops();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
